adder_share_arb: RTL
====================

Name: adder_share_arb

Overview:
- Round-robin arbiter and sequencer sharing one combinational 4-bit adder / 7-segment decoder datapath (project2_m: a, b, s -> lcd[6:0], lcd_o) among NREQ requesters.
- Latches the winning requester's operands into registers driving the datapath, waits one settle cycle, captures lcd/overflow into a result register, and acknowledges the requester.
- Sits between the operand sources (switch/keypad front-ends) and the single shared project2_m instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester index; ceil(log2(NREQ)).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request; level, held until ack.
- a_in  in  4*NREQ  operand A per requester; channel i at [4i+3:4i].
- b_in  in  4*NREQ  operand B per requester, same packing.
- s_in  in  NREQ  s control bit per requester.
- ack  out  NREQ  one-cycle completion pulse for the granted channel.
- dp_a  out  4  registered A to shared datapath.
- dp_b  out  4  registered B to shared datapath.
- dp_s  out  1  registered s to shared datapath.
- dp_lcd  in  7  datapath segment result.
- dp_ovf  in  1  datapath overflow (lcd_o).
- res_lcd  out  7  captured segment result.
- res_ovf  out  1  captured overflow.
- res_id  out  ID_W  channel that produced res_*.
- res_valid  out  1  one-cycle pulse when res_* update.
- busy  out  1  high in ISSUE and CAPTURE.

Behaviour:
- Reset (rst high at an edge): state IDLE; ack=0, res_valid=0, res_lcd=0, res_ovf=0, res_id=0, dp_a=0, dp_b=0, dp_s=0, busy=0; priority pointer=0. Reset has priority over all other activity.
- States:
  - IDLE: eligible = req & ~ack. If any channel is eligible, grant the first eligible channel at or after the pointer, searching upward with wrap at NREQ. At the edge, load dp_a/dp_b/dp_s from that channel, latch the grant id, and go to ISSUE. If none is eligible, stay in IDLE.
  - ISSUE: dp_* held stable for one settle cycle; unconditionally go to CAPTURE.
  - CAPTURE: at the edge, register res_lcd<=dp_lcd, res_ovf<=dp_ovf, res_id<=grant id; set res_valid=1 and ack[id]=1; pointer <= (id+1) mod NREQ; go to IDLE.
- ack and res_valid are high for exactly the one cycle following the CAPTURE edge, otherwise 0. At most one ack bit is set at a time.
- Latency: req sampled in IDLE at edge t0 -> dp_* valid after t0 -> capture at t0+2 -> ack/res_valid high in cycle t0+2..t0+3. Throughput is one transaction per 3 cycles when requests are back-to-back.
- Requester must deassert req in the cycle ack is high; the ~ack mask prevents a double grant in that cycle. req still high the following cycle is a new request.
- Operands are latched at grant. Changes to a_in/b_in/s_in, or dropping req, after grant do not affect the in-flight transaction, which completes and acks normally.
- res_* hold their value until the next CAPTURE. dp_* hold their value in IDLE (no return to zero).
- Simultaneous requests: strict round-robin from the pointer, so no channel waits more than NREQ-1 transactions.
- Arithmetic and decoding are entirely in the datapath; this block passes 4-bit operands unmodified, with no width extension.
- Reset mid-transaction (ISSUE or CAPTURE): transaction abandoned, no ack issued, pointer returns to 0.

Test Plan:
- Single request: req=0001, ch0 a=3 b=4 s=0 -> dp_a=3, dp_b=4 one cycle after grant; 3 cycles after req: res_lcd=0000111, res_ovf=0, res_id=0, ack=0001 and res_valid for 1 cycle.
- Overflow path: ch1 a=10 b=0 s=0 -> res_lcd=0000000, res_ovf=1, res_id=1, ack=0010.
- Contention: req=1111 raised together, each channel dropping req on its ack -> acks in order ch0, ch1, ch2, ch3, spaced 3 cycles apart; busy continuously high apart from the 1-cycle IDLE gaps.
- Fairness: ch0 re-requests immediately after every ack, ch2 holds req -> grant order 0,2,0,2; ch0 is never granted twice in a row while ch2 is pending.
- Operand stability: change ch0 a_in from 5 to 9 in the ISSUE cycle -> res_lcd=1101101 (5), not 9.
- Reset mid-op: assert rst in the ISSUE cycle -> no ack; all outputs 0 next cycle; with req=0101 pending afterwards, ch0 is granted first.

Source files
------------

// File: rtl/adder_share_arb.sv
// Round-robin arbiter that time-shares one external adder/7-segment datapath
// among NREQ requesters: grant, settle one cycle, capture, acknowledge.
module adder_share_arb #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] a_in,
  input  logic [4*NREQ-1:0] b_in,
  input  logic [NREQ-1:0]   s_in,
  output logic [NREQ-1:0]   ack,
  output logic [3:0]        dp_a,
  output logic [3:0]        dp_b,
  output logic              dp_s,
  input  logic [6:0]        dp_lcd,
  input  logic              dp_ovf,
  output logic [6:0]        res_lcd,
  output logic              res_ovf,
  output logic [ID_W-1:0]   res_id,
  output logic              res_valid,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t          state;
  state_t          next_state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] pick;
  logic            found;
  logic [NREQ-1:0] eligible;
  int              idx;

  // A channel whose ack is high this cycle is masked so it cannot be granted twice.
  always_comb begin
    eligible = req & ~ack;
    found    = 1'b0;
    pick     = '0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (found) next_state = ISSUE;
      ISSUE:   next_state = CAPTURE;
      CAPTURE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Operands are frozen at grant; dp_* keep their last value while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_a      <= '0;
      dp_b      <= '0;
      dp_s      <= 1'b0;
      grant_id  <= '0;
      ptr       <= '0;
      res_lcd   <= '0;
      res_ovf   <= 1'b0;
      res_id    <= '0;
      res_valid <= 1'b0;
      ack       <= '0;
    end else begin
      res_valid <= 1'b0;
      ack       <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            dp_a     <= a_in[4*pick +: 4];
            dp_b     <= b_in[4*pick +: 4];
            dp_s     <= s_in[pick];
            grant_id <= pick;
          end
        end
        CAPTURE: begin
          res_lcd   <= dp_lcd;
          res_ovf   <= dp_ovf;
          res_id    <= grant_id;
          res_valid <= 1'b1;
          ack       <= NREQ'(1) << grant_id;
          if (grant_id == ID_W'(NREQ - 1)) ptr <= '0;
          else                             ptr <= grant_id + ID_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
